// File: rtl/wave_player.sv
// Wavetable playback engine.
// Runs a fractional phase accumulator over a window [base, base+len) of the
// waveform RAM, issues one read per output sample and streams samples out
// over a valid/ready handshake.
// Ports:
//   i_clk, i_res      clock, synchronous active-low reset
//   i_en              level request for playback
//   i_tuning          phase increment (integer part in upper ADDRESS_SIZE bits)
//   i_base, i_len     window start address and length (1..2^ADDRESS_SIZE)
//   ram_addr, ram_re  RAM read port; ram_r_data returns one cycle later
//   o_sample, o_valid, i_ready  output stream
//   o_busy            not idle
//   o_cfg_err         last start request carried an illegal configuration
module wave_player #(
  parameter int unsigned ADDRESS_SIZE = 8,
  parameter int unsigned DATA_SIZE    = 8,
  parameter int unsigned PHASE_SIZE   = 24
) (
  input  logic                    i_clk,
  input  logic                    i_res,
  input  logic                    i_en,
  input  logic [PHASE_SIZE-1:0]   i_tuning,
  input  logic [ADDRESS_SIZE-1:0] i_base,
  input  logic [ADDRESS_SIZE:0]   i_len,
  output logic [ADDRESS_SIZE-1:0] ram_addr,
  output logic                    ram_re,
  input  logic [DATA_SIZE-1:0]    ram_r_data,
  output logic [DATA_SIZE-1:0]    o_sample,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic                    o_busy,
  output logic                    o_cfg_err
);

  localparam int unsigned FRAC = PHASE_SIZE - ADDRESS_SIZE;
  localparam logic [ADDRESS_SIZE:0] MaxLen = {1'b1, {ADDRESS_SIZE{1'b0}}};

  typedef enum logic [1:0] {StIdle, StFetch, StWait, StHold} state_e;

  state_e                  state_q, state_d;
  logic [ADDRESS_SIZE-1:0] idx_q, base_q, addr_q;
  logic [FRAC-1:0]         frac_q;
  logic [PHASE_SIZE-1:0]   tun_q;
  logic [ADDRESS_SIZE:0]   len_q;
  logic [DATA_SIZE-1:0]    sample_q;
  logic                    cfg_err_q;

  logic                    cfg_legal, start, accept;
  logic [FRAC:0]           fsum;
  logic [ADDRESS_SIZE:0]   isum, iwrap;

  // Legal: 1 <= len <= 2^ADDRESS_SIZE and integer step < len.
  assign cfg_legal = (i_len != '0) && (i_len <= MaxLen) &&
                     ({1'b0, i_tuning[PHASE_SIZE-1 -: ADDRESS_SIZE]} < i_len);
  assign start  = (state_q == StIdle) && i_en && cfg_legal;
  assign accept = (state_q == StHold) && i_ready;

  // Phase advance; tun_int < len bounds isum below 2*len, so one subtraction wraps it.
  assign fsum  = {1'b0, frac_q} + {1'b0, tun_q[FRAC-1:0]};
  assign isum  = {1'b0, idx_q} + {1'b0, tun_q[PHASE_SIZE-1 -: ADDRESS_SIZE]} +
                 {{ADDRESS_SIZE{1'b0}}, fsum[FRAC]};
  assign iwrap = (isum >= len_q) ? (isum - len_q) : isum;

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_res) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StFetch;
      StFetch: state_d = StWait;
      StWait:  state_d = StHold;
      StHold:  if (i_ready) state_d = i_en ? StFetch : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs; the address is only recomputed in FETCH and held otherwise.
  always_comb begin
    ram_re   = (state_q == StFetch);
    o_valid  = (state_q == StHold);
    o_busy   = (state_q != StIdle);
    ram_addr = (state_q == StFetch) ? (base_q + idx_q) : addr_q;
  end

  assign o_sample  = sample_q;
  assign o_cfg_err = cfg_err_q;

  // Datapath and configuration registers
  always_ff @(posedge i_clk) begin
    if (!i_res) begin
      idx_q     <= '0;
      frac_q    <= '0;
      tun_q     <= '0;
      base_q    <= '0;
      len_q     <= '0;
      addr_q    <= '0;
      sample_q  <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      addr_q <= ram_addr;
      if (state_q == StIdle && i_en) cfg_err_q <= !cfg_legal;
      if (start) begin
        tun_q  <= i_tuning;
        base_q <= i_base;
        len_q  <= i_len;
        idx_q  <= '0;
        frac_q <= '0;
      end else if (accept) begin
        idx_q  <= iwrap[ADDRESS_SIZE-1:0];
        frac_q <= fsum[FRAC-1:0];
      end
      if (state_q == StWait) sample_q <= ram_r_data;
    end
  end

endmodule
